seq_alu: RTL
============

# seq_alu

Parametrised, handshaked successor to the single-cycle datapath ALU: accepts one operation per transaction on a valid/ready input port, computes add, subtract, multiply, divide or pass-through at WIDTH bits, and returns a registered result with flags on a valid/ready output port. Division is computed iteratively over WIDTH cycles by a restoring divider; all other operations complete in one cycle. It sits between the core's operand registers and the writeback path of the matrix-multiply datapath.

## Interface
- WIDTH, 16, operand and result width in bits (≥2)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation this cycle
- in1  input  WIDTH  operand A (unsigned)
- in2  input  WIDTH  operand B (unsigned)
- alu_op  input  3  0 add, 1 sub, 2 mul, 3 div, 4 pass, 5–7 treated as add
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result
- alu_out  output  WIDTH  result
- z  output  1  alu_out == 0
- c  output  1  add carry-out / sub borrow; 0 otherwise
- err  output  1  divide-by-zero or divide not built

## Operation
- Arithmetic unsigned, modulo 2^WIDTH.
- add: in1+in2, c = bit WIDTH of sum. sub: in2−in1, c = 1 iff in1>in2. mul: low WIDTH bits of in1·in2, c=0. pass: in2. div: in1/in2 (quotient, truncated).
- Divide by zero: alu_out all ones, err=1, z=0, 1-cycle latency (no iteration).
- z is computed from the result being registered in the same cycle, never from the previous result.
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready); allows back-to-back single-cycle ops at full throughput.
- States: IDLE → (accept div, in2≠0) → DIV → (WIDTH iterations complete) → IDLE with out_valid=1. All other accepts stay in IDLE and load the output register directly.
- Output register and flags hold stable while out_valid && !out_ready.
- Operands captured on accept; later changes to in1/in2/alu_op are ignored.

## Timing
- Reset values: in_ready 0 during reset then 1, out_valid 0, alu_out 0, z 0, c 0, err 0, state IDLE, divider counter 0.
- Non-div latency: accept at edge N → out_valid high after edge N (visible in cycle N+1).
- Div latency: accept at edge N → out_valid high after edge N+WIDTH+1; in_ready low for those cycles.
- Reset mid-divide: iteration aborted, no result issued, IDLE on release.
- Simultaneous output drain and new accept in the same cycle: new result replaces the old one, out_valid stays 1.

## Configuration
- SEQ_ALU_DIV_EN defined: divider instantiated, op 3 behaves as above.
- Not defined: no divider logic; op 3 completes in 1 cycle with alu_out all ones, err=1, c=0, z=0; state never leaves IDLE.

## Structure
- Package alu_pkg: op-code constants (ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_DIV=3, ALU_PASS=4), state encoding (IDLE, DIV).
- Sub-module seq_divider (parameter WIDTH): start/busy/done, restoring shift-subtract, one quotient bit per cycle; guarded by SEQ_ALU_DIV_EN.

## Test plan (WIDTH=16)
- add 0xFFFF+0x0001, out_ready=1 → alu_out 0x0000, z=1, c=1, one cycle after accept.
- sub in1=5, in2=3 → alu_out 0xFFFE, c=1, z=0; then in1=3, in2=3 → 0x0000, z=1, c=0.
- div 1000/7 with SEQ_ALU_DIV_EN → in_ready low 17 cycles, alu_out 142, err=0; without macro → 0xFFFF, err=1 after 1 cycle.
- div 9/0 → alu_out 0xFFFF, err=1 after 1 cycle.
- mul 0x0100·0x0100 with out_ready=0 for 5 cycles → alu_out 0x0000, z=1 held stable, in_ready low until drained.
- Assert reset 4 cycles into a divide → out_valid stays 0, all outputs 0; next add 2+2 → 4.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// alu_pkg: op-code constants and controller state encoding shared by seq_alu.
// Revision 1.0 - initial release.
`default_nettype none

package alu_pkg;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_MUL  = 3'd2;
   localparam logic [2:0] ALU_DIV  = 3'd3;
   localparam logic [2:0] ALU_PASS = 3'd4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      DIV  = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_alu_if.sv
// seq_alu_if: operation-in / result-out valid-ready bundle for seq_alu.
// Revision 1.0 - initial release.
`default_nettype none

interface seq_alu_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [2:0]       alu_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic             z;
   logic             c;
   logic             err;

   modport master (
      output in_valid, in1, in2, alu_op, out_ready,
      input  in_ready, out_valid, alu_out, z, c, err
   );

   modport slave (
      input  in_valid, in1, in2, alu_op, out_ready,
      output in_ready, out_valid, alu_out, z, c, err
   );
endinterface

`default_nettype wire

// File: rtl/seq_alu_divider.sv
// seq_divider: restoring shift-subtract unsigned divider, one quotient bit per cycle.
// Revision 1.0 - initial release. Only instantiated when SEQ_ALU_DIV_EN is defined.
`default_nettype none

module seq_divider #(
   parameter int WIDTH = 16
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic             start_i,
   input  wire logic [WIDTH-1:0] dividend_i,
   input  wire logic [WIDTH-1:0] divisor_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [WIDTH-1:0]      quotient_o
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Partial remainder picks up the next dividend bit from the top of the quotient shifter.
   assign shifted = {rem_q, quot_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_q};

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quot_d = quot_q;
      dvs_d  = dvs_q;
      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = CW'(WIDTH);
         rem_d  = '0;
         quot_d = dividend_i;
         dvs_d  = divisor_i;
      end else if (busy_q) begin
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CW'(1);
            if (!trial[WIDTH]) begin
               rem_d  = trial[WIDTH-1:0];
               quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d  = shifted[WIDTH-1:0];
               quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quot_q <= '0;
         dvs_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quot_q <= quot_d;
         dvs_q  <= dvs_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = busy_q && (cnt_q == '0);
   assign quotient_o = quot_q;

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// seq_alu: handshaked WIDTH-bit ALU (add/sub/mul/div/pass) with registered result and flags.
// Revision 1.0 - initial release. Define SEQ_ALU_DIV_EN to build the iterative divider.
`default_nettype none

module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  wire logic clock,
   input  wire logic reset,
   seq_alu_if.slave  bus
);
   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             z_q, z_d;
   logic             c_q, c_d;
   logic             err_q, err_d;

   logic             accept;
   logic             div_go;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] calc_res;
   logic             calc_c;
   logic             calc_err;

   assign bus.in_ready = !reset && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign sum          = {1'b0, bus.in1} + {1'b0, bus.in2};

   always_comb begin
      calc_res = sum[WIDTH-1:0];
      calc_c   = sum[WIDTH];
      calc_err = 1'b0;
      case (bus.alu_op)
         ALU_SUB: begin
            calc_res = bus.in2 - bus.in1;
            calc_c   = bus.in1 > bus.in2;
         end
         ALU_MUL: begin
            calc_res = bus.in1 * bus.in2;
            calc_c   = 1'b0;
         end
         ALU_DIV: begin
            // Divide-by-zero and divider-absent both resolve here in one cycle.
            calc_res = '1;
            calc_c   = 1'b0;
            calc_err = 1'b1;
         end
         ALU_PASS: begin
            calc_res = bus.in2;
            calc_c   = 1'b0;
         end
         default: ;
      endcase
   end

`ifdef SEQ_ALU_DIV_EN
   logic             div_busy;
   logic             div_done;
   logic [WIDTH-1:0] div_quot;

   assign div_go = (bus.alu_op == ALU_DIV) && (bus.in2 != '0);

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clock      (clock),
      .reset      (reset),
      .start_i    (accept && div_go),
      .dividend_i (bus.in1),
      .divisor_i  (bus.in2),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (div_quot)
   );
`else
   assign div_go = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      z_d         = z_q;
      c_d         = c_q;
      err_d       = err_q;
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (div_go) begin
                  state_d = DIV;
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = calc_res;
                  z_d         = (calc_res == '0);
                  c_d         = calc_c;
                  err_d       = calc_err;
               end
            end
         end
         DIV: begin
`ifdef SEQ_ALU_DIV_EN
            if (div_done) begin
               state_d     = IDLE;
               out_valid_d = 1'b1;
               result_d    = div_quot;
               z_d         = (div_quot == '0);
               c_d         = 1'b0;
               err_d       = 1'b0;
            end else if (!div_busy) begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         z_q         <= 1'b0;
         c_q         <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         z_q         <= z_d;
         c_q         <= c_d;
         err_q       <= err_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.alu_out   = result_q;
   assign bus.z         = z_q;
   assign bus.c         = c_q;
   assign bus.err       = err_q;

endmodule

`default_nettype wire
